dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the pipeline's MEM stage (EX/MEM address and store data) and a slow line-wide backing data memory.
- Serves hits in the same cycle with no stall.
- On a miss, stalls the pipeline, writes back the dirty victim line if needed, refills the line, then completes the access.

---
 rtl/dcache_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate D-cache controller.
// Define DCACHE_STATS_EN to add hit/miss/writeback counters.
module dcache_ctrl #(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_W         = 32 * WORDS_PER_LINE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o,
  output logic [31:0]       stat_wb_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int LSB_W = OFF_W + 2;
  localparam int TAG_W = 32 - IDX_W - LSB_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RF
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [LINE_W-1:0] w_line;
  logic [31:0]       w_word;
  logic              w_match;
  logic              w_idle;
  logic              w_hit;
  logic              w_miss;
  logic              w_st_hit;
  logic              w_rf_ack;
  logic              w_wb_ack;
  logic              w_stall;
  logic              w_unused;

  assign w_off    = cpu_addr_i[LSB_W-1:2];
  assign w_idx    = cpu_addr_i[LSB_W +: IDX_W];
  assign w_tag    = cpu_addr_i[31 -: TAG_W];
  assign w_line   = r_data[w_idx];
  assign w_word   = w_line[{w_off, 5'b0} +: 32];
  assign w_match  = r_valid[w_idx] &
                    (r_tag[w_idx] == w_tag);
  assign w_idle   = (r_state == S_IDLE);
  assign w_hit    = cpu_req_i & w_match & w_idle;
  assign w_miss   = cpu_req_i & ~w_match & w_idle;
  assign w_st_hit = w_hit & cpu_we_i;
  assign w_rf_ack = (r_state == S_RF) & mem_ack_i;
  assign w_wb_ack = (r_state == S_WB) & mem_ack_i;
  assign w_unused = &{1'b0, cpu_addr_i[1:0]};

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_stall = 1'b1;
          w_next  = (r_valid[w_idx] & r_dirty[w_idx])
                    ? S_WB : S_RF;
        end
      end
      S_WB: begin
        w_stall     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_tag[w_idx], w_idx,
                       {LSB_W{1'b0}}};
        mem_wdata_o = w_line;
        if (mem_ack_i) w_next = S_RF;
      end
      S_RF: begin
        w_stall    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {w_tag, w_idx, {LSB_W{1'b0}}};
        if (mem_ack_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // stall must read low while reset is held, even on a pending miss
  assign cpu_stall_o = w_stall & rst_i;
  assign cpu_rdata_o = (w_hit & ~cpu_we_i) ? w_word : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_rf_ack) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_st_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rf_ack) begin
      r_data[w_idx] <= mem_rdata_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_st_hit) begin
      r_data[w_idx][{w_off, 5'b0} +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit)    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss)   r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_ack) r_wb_cnt   <= r_wb_cnt + 32'd1;
    end
  end

  assign stat_hit_o  = r_hit_cnt;
  assign stat_miss_o = r_miss_cnt;
  assign stat_wb_o   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: flat-memory reference model,
// randomized accesses and memory latencies.
module tb_dcache_ctrl;

  localparam int NL  = 32;
  localparam int WPL = 4;
  localparam int LW  = 32 * WPL;

  logic          clk_i;
  logic          rst_i;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [31:0]   cpu_addr_i;
  logic [31:0]   cpu_wdata_i;
  logic [31:0]   cpu_rdata_o;
  logic          cpu_stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i;
  logic          mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_hit_o;
  logic [31:0]   stat_miss_o;
  logic [31:0]   stat_wb_o;
`endif

  dcache_ctrl #(
    .NUM_LINES(NL),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cpu_req_i(cpu_req_i),
    .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit_o(stat_hit_o),
    .stat_miss_o(stat_miss_o),
    .stat_wb_o(stat_wb_o)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
  } xfer_t;

  int n_chk;
  int n_err;
  int n_hit;
  int n_miss;
  int n_wb;
  int lat_wb;
  int lat_rf;
  int mcnt;

  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_v   [NL];
  bit          ref_d   [NL];
  logic [31:0] ref_t   [NL];
  xfer_t       xfers[$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(
    input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] b_rd(
    input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(
    input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a]
                             : init_word(a);
  endfunction

  // backing memory: ack after lat cycles of request
  always @(negedge clk_i) begin
    logic was;
    int   lat;
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      mcnt = 0;
    end else begin
      was = mem_ack_i;
      mem_ack_i = 1'b0;
      if (was) mcnt = 0;
      if (mem_req_o) begin
        lat = mem_we_o ? lat_wb : lat_rf;
        if (mcnt >= lat) begin
          mem_ack_i = 1'b1;
          xfers.push_back('{mem_we_o, mem_addr_o});
          for (int k = 0; k < WPL; k++) begin
            if (mem_we_o)
              bmem[mem_addr_o + 32'(4*k)] =
                mem_wdata_o[32*k +: 32];
            else
              mem_rdata_i[32*k +: 32] =
                b_rd(mem_addr_o + 32'(4*k));
          end
        end else begin
          mcnt++;
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk_i);
    cpu_req_i = 1'b0;
  endtask

  task automatic do_access(input bit we,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input int lwb,
                           input int lrf);
    int          idx;
    logic [31:0] tag;
    logic [31:0] va;
    logic [31:0] la;
    bit          miss;
    bit          wb;
    int          cyc;
    int          exp;
    idx  = int'((a >> 4) % NL);
    tag  = a >> 9;
    la   = a & ~32'hF;
    miss = !(ref_v[idx] && ref_t[idx] == tag);
    wb   = miss && ref_d[idx];
    va   = (ref_t[idx] << 9) | 32'(idx << 4);
    lat_wb = lwb;
    lat_rf = lrf;
    xfers.delete();
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    cyc = 0;
    #1;
    while (cpu_stall_o && cyc < 200) begin
      cyc++;
      @(negedge clk_i);
      #1;
    end
    exp = miss ? (1 + (wb ? lwb + 1 : 0) + lrf + 1) : 0;
    chk("stall_cyc", 32'(cyc), 32'(exp));
    if (!we) chk("rdata", cpu_rdata_o, ref_rd(a));
    else     chk("st_rdata", cpu_rdata_o, 32'h0);
    chk("xfer_n", 32'(xfers.size()),
        miss ? (wb ? 32'd2 : 32'd1) : 32'd0);
    if (wb && xfers.size() == 2) begin
      chk("wb_addr", xfers[0].addr, va);
      chk("wb_we", 32'(xfers[0].we), 32'd1);
      for (int k = 0; k < WPL; k++)
        chk("wb_data", b_rd(va + 32'(4*k)),
            ref_rd(va + 32'(4*k)));
    end
    if (miss && xfers.size() > 0) begin
      chk("rf_addr", xfers[$].addr, la);
      chk("rf_we", 32'(xfers[$].we), 32'd0);
    end
    @(posedge clk_i);
    if (miss) begin
      n_miss++;
      if (wb) n_wb++;
      ref_v[idx] = 1'b1;
      ref_t[idx] = tag;
      ref_d[idx] = 1'b0;
    end
    if (we) begin
      ref_mem[a] = d;
      ref_d[idx] = 1'b1;
    end
    n_hit++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      ref_v[i] = 1'b0;
      ref_d[i] = 1'b0;
    end
    ref_mem = bmem;
    n_hit  = 0;
    n_miss = 0;
    n_wb   = 0;
  endtask

  task automatic chk_stats();
`ifdef DCACHE_STATS_EN
    chk("stat_hit", stat_hit_o, 32'(n_hit));
    chk("stat_miss", stat_miss_o, 32'(n_miss));
    chk("stat_wb", stat_wb_o, 32'(n_wb));
`endif
  endtask

  function automatic logic [31:0] rnd_addr();
    return (32'($urandom_range(0, 3)) << 9) |
           (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  found;
    bit  we;
    n_chk = 0;
    n_err = 0;
    lat_wb = 0;
    lat_rf = 0;
    mcnt = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    rst_i       = 1'b0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h40;
    cpu_wdata_i = '0;
    model_reset();
    #12;
    chk("rst_stall", 32'(cpu_stall_o), 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_mwe", 32'(mem_we_o), 32'd0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;

    bmem[32'h40] = 32'hA;
    bmem[32'h44] = 32'hB;
    bmem[32'h48] = 32'hC;
    bmem[32'h4C] = 32'hD;
    ref_mem = bmem;

    do_access(1'b0, 32'h40, 32'h0, 0, 3);
    do_access(1'b1, 32'h44, 32'hDEADBEEF, 0, 0);
    do_access(1'b0, 32'h44, 32'h0, 0, 0);
    do_access(1'b0, 32'h244, 32'h0, 2, 1);
    chk("wb_beef", b_rd(32'h44), 32'hDEADBEEF);
    chk_stats();
    idle();
    do_access(1'b0, 32'h80, 32'h0, 1, 1);
    do_access(1'b0, 32'h280, 32'h0, 1, 2);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      do_access(we, rnd_addr(), $urandom,
                $urandom_range(0, 3),
                $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    chk_stats();

    lat_wb = 1;
    lat_rf = 20;
    xfers.delete();
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'hE40;
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk_i);
      #1;
      if (mem_req_o && !mem_we_o) found = 1;
    end
    chk("rf_reach", 32'(found), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_mreq", 32'(mem_req_o), 32'd0);
    chk("mid_stall", 32'(cpu_stall_o), 32'd0);
    chk("mid_rdata", cpu_rdata_o, 32'h0);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    chk_stats();

    do_access(1'b0, 32'hE40, 32'h0, 0, 2);
    for (int i = 0; i < 30; i++)
      do_access(1'b0, rnd_addr(), 32'h0,
                $urandom_range(0, 3),
                $urandom_range(0, 3));
    idle();
    chk_stats();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
